norm_32: RTL
============

Name: norm_32

Overview:
- Multi-cycle 32-bit normalizer. It is the inverse companion of the barrel shifter (bshift_32).
- Given an operand, it finds the left-shift amount that normalizes it and returns both the shift count and the normalized value.
- Logical mode counts leading zeros. Arithmetic mode counts redundant sign bits.
- Sits beside the shifter in the execute stage. It feeds count/clz-type instructions and the shift amount for software float normalization, using a valid/ready handshake on both sides.

Parameters:
- none (fixed 32-bit datapath, 5 iteration steps)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand
- a  input  32  operand
- arith  input  1  1 = count redundant sign bits, 0 = count leading zeros
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- q  output  32  normalized value (a shifted left by cnt, clamped to 31)
- cnt  output  6  shift count, 0..32
- z  output  1  operand was zero

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, q=0, cnt=0, z=0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture a into working register v, capture arith, set cnt=0, set z=(a==0), step=4, go to RUN.
  - RUN: in_ready=0, out_valid=0. One step per cycle with s=2^step (16,8,4,2,1).
    - Logical: if v[31:32-s] are all zero, then v<=v<<s and cnt<=cnt+s.
    - Arith: if v[31:31-s] (s+1 bits) are all equal, then v<=v<<s and cnt<=cnt+s.
    - After step 0 executes, go to DONE.
  - DONE: out_valid=1, and q/cnt/z are held stable. On out_valid&out_ready, go to IDLE. in_ready rises the following cycle.
- Final count correction: on entering DONE, if logical and z=1, cnt becomes 32 and q becomes 0. Otherwise cnt is the iterated sum, at most 31.
- Arith zero and all-ones operands: cnt=31, q=a<<31, so 0x00000000 for a=0 and 0x80000000 for a=0xFFFFFFFF. z=1 only for a=0.
- Latency:
  - Accept edge T0; steps occur at edges T1..T5; out_valid is high after T5.
  - Minimum period between accepts is 7 cycles (accept, 5 steps, 1 DONE cycle with out_ready=1).
- No overlap: in_valid is ignored outside IDLE. The operand is sampled only on the accepting edge, so a changing after acceptance has no effect.
- Backpressure: out_ready low holds DONE indefinitely with outputs unchanged.
- Outputs q/cnt/z keep their last values in IDLE and RUN, but are only meaningful while out_valid=1.
- Reset mid-operation: any state returns immediately to IDLE. The in-flight operand is discarded and no out_valid pulse is produced.
- Widths: cnt is 6 bits, so no overflow is possible (max 32). Shifts fill with zeros from the right in both modes.

Optional Feature:
- Macro: NORM32_FLUSH_EN
- With the macro: adds input port flush (1 bit, synchronous).
  - flush=1 in RUN or DONE returns to IDLE at the next edge, drops the result and deasserts out_valid.
  - flush in IDLE has no effect, and in_valid is ignored in that cycle.
  - flush has priority over the out handshake in the same cycle. The result is counted as not delivered.
- Without the macro: no flush port. Only rst aborts an operation.

Test Plan:
- Logical a=0x00010000, out_ready=1 -> out_valid after exactly 5 step edges; cnt=15, q=0x80000000, z=0.
- Logical a=0x00000000 -> cnt=32, q=0x00000000, z=1. Logical a=0x80000000 -> cnt=0, q=0x80000000.
- Arith a=0xFFFF8000 -> cnt=16, q=0x80000000. Arith a=0x00000001 -> cnt=30, q=0x40000000. Arith a=0xFFFFFFFF -> cnt=31, q=0x80000000, z=0.
- Backpressure: hold out_ready=0 for 4 cycles in DONE while driving in_valid=1 with a new operand -> q/cnt/z stable, in_ready=0, new operand not accepted. Raise out_ready -> single transfer, in_ready=1 next cycle, then the new operand is accepted.
- Assert rst asynchronously mid-RUN (step 2) -> out_valid=0, in_ready=1 immediately. The next operand a=0x0000FFFF (logical) yields cnt=16, q=0xFFFF0000.
- NORM32_FLUSH_EN build: flush in RUN -> no out_valid, back in IDLE next cycle. flush with out_ready=1 in DONE -> result dropped.

Source files
------------

// File: rtl/norm_32_if.sv
// norm_32_if: operand/result handshake bundle for the 32-bit normalizer.
// Ports: in_valid/in_ready/a/arith carry the operand, and out_valid/out_ready/q/cnt/z carry the result.
// Optional: NORM32_FLUSH_EN adds a synchronous flush driven by the master side.
interface norm_32_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q;
  logic [5:0]  cnt;
  logic        z;
`ifdef NORM32_FLUSH_EN
  logic        flush;

  modport master (output in_valid, a, arith, out_ready, flush,
                  input  in_ready, out_valid, q, cnt, z);
  modport slave  (input  in_valid, a, arith, out_ready, flush,
                  output in_ready, out_valid, q, cnt, z);
`else
  modport master (output in_valid, a, arith, out_ready,
                  input  in_ready, out_valid, q, cnt, z);
  modport slave  (input  in_valid, a, arith, out_ready,
                  output in_ready, out_valid, q, cnt, z);
`endif
endinterface

// File: rtl/norm_32.sv
// norm_32: multi-cycle normalizer that returns the leading-zero count (logical) or the redundant-sign-bit count (arith) and the operand shifted left by that count.
// Latency: accept edge, then 5 binary-search step edges, then the result is held in DONE until out_ready is high. Accepts are at least 7 cycles apart.
// Ports: clk, rst (async, active-high), bus (norm_32_if.slave). Optional macro NORM32_FLUSH_EN enables bus.flush to abort RUN/DONE.
module norm_32 (
  input  logic       clk,
  input  logic       rst,
  norm_32_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] v_q, v_d;         // working value, shifted in place
  logic [5:0]  wcnt_q, wcnt_d;   // running shift sum
  logic        wz_q, wz_d;       // operand was zero
  logic        arith_q, arith_d;
  logic [2:0]  step_q, step_d;   // shift this step = 2^step
  logic [31:0] q_q, q_d;         // published result, only updated on entering DONE
  logic [5:0]  cnt_q, cnt_d;
  logic        z_q, z_d;

  logic        flush_w;
  logic [5:0]  s;
  logic [31:0] mask_lz, mask_sg;
  logic        take;

`ifdef NORM32_FLUSH_EN
  assign flush_w = bus.flush;
`else
  assign flush_w = 1'b0;
`endif

  // Top s bits for the zero test, and top s+1 bits for the sign-run test
  // (the surviving bit must still equal the sign bits being shifted out).
  assign s       = 6'd1 << step_q;
  assign mask_lz = ~(32'hFFFF_FFFF >> s);
  assign mask_sg = ~(32'hFFFF_FFFF >> (s + 6'd1));
  assign take    = arith_q ? (((v_q & mask_sg) == 32'd0) || ((v_q & mask_sg) == mask_sg))
                           : ((v_q & mask_lz) == 32'd0);

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    wcnt_d  = wcnt_q;
    wz_d    = wz_q;
    arith_d = arith_q;
    step_d  = step_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    case (state_q)
      IDLE: begin
        // A flush in IDLE also blocks acceptance during that cycle.
        if (bus.in_valid && !flush_w) begin
          v_d     = bus.a;
          arith_d = bus.arith;
          wcnt_d  = 6'd0;
          wz_d    = (bus.a == 32'd0);
          step_d  = 3'd4;
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush_w) begin
          state_d = IDLE;
        end else begin
          if (take) begin
            v_d    = v_q << s;
            wcnt_d = wcnt_q + s;
          end
          if (step_q == 3'd0) begin
            state_d = DONE;
            z_d     = wz_q;
            // A logical zero operand sums to 31. It reports the full width.
            if (!arith_q && wz_q) begin
              q_d   = 32'd0;
              cnt_d = 6'd32;
            end else begin
              q_d   = v_d;
              cnt_d = wcnt_d;
            end
          end else begin
            step_d = step_q - 3'd1;
          end
        end
      end
      DONE: begin
        // A flush takes priority. The result counts as undelivered.
        if (flush_w || bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      v_q     <= 32'd0;
      wcnt_q  <= 6'd0;
      wz_q    <= 1'b0;
      arith_q <= 1'b0;
      step_q  <= 3'd0;
      q_q     <= 32'd0;
      cnt_q   <= 6'd0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      wcnt_q  <= wcnt_d;
      wz_q    <= wz_d;
      arith_q <= arith_d;
      step_q  <= step_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.q         = q_q;
  assign bus.cnt       = cnt_q;
  assign bus.z         = z_q;

endmodule
